dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single-port 16x32 data memory file.
- Shares the memory between requester A (CPU load/store stage) and requester B (debug/loader port).
- Uses a 3-state FSM with round-robin priority. Each transaction latches the command, drives exactly one memory access cycle, returns read data with a one-cycle done pulse, and then frees the memory.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dmem_arbiter                                                   |
// | Purpose : Two-requester arbiter/sequencer for a single-port 16x32 data   |
// |           memory. Each granted transaction latches its command, drives   |
// |           one memory access cycle, then pulses done for one cycle.       |
// |           Ties are broken round robin.                                   |
// | Ports   : clk, rst          - clock, async active-high reset             |
// |           a_*/b_*           - requester A (CPU) / B (debug) handshake,   |
// |                               command, done pulse and load result        |
// |           mem_en/we/addr/wdata, mem_rdata - memory access interface      |
// |           busy              - high while a transaction is in flight      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic c_GNT_A = 1'b0;
  localparam logic c_GNT_B = 1'b1;

  state_t            r_state;
  logic              r_last_gnt;
  logic              r_gnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_a_done;
  logic              r_b_done;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_busy;

  logic              w_pick_b;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // B wins when it is the only requester, or when both request and A was
  // the most recent grant.
  always_comb begin
    w_pick_b = b_req & (~a_req | (r_last_gnt == c_GNT_A));
    w_we     = w_pick_b ? b_we    : a_we;
    w_addr   = w_pick_b ? b_addr  : a_addr;
    w_wdata  = w_pick_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_gnt <= c_GNT_B;
      r_gnt      <= c_GNT_A;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_a_done   <= 1'b0;
      r_b_done   <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (a_req | b_req) begin
            // The command is captured here only; later input changes are
            // invisible to the transaction in flight.
            r_gnt    <= w_pick_b;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_mem_en <= 1'b1;
            r_mem_we <= w_we;
            r_busy   <= 1'b1;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            if (r_gnt == c_GNT_B) begin
              r_b_rdata <= mem_rdata;
            end else begin
              r_a_rdata <= mem_rdata;
            end
          end
          r_mem_en   <= 1'b0;
          r_mem_we   <= 1'b0;
          r_a_done   <= (r_gnt == c_GNT_A);
          r_b_done   <= (r_gnt == c_GNT_B);
          r_last_gnt <= r_gnt;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_a_done <= 1'b0;
          r_b_done <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_a_done <= 1'b0;
          r_b_done <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Address and write data come straight from the latched command, so they
  // hold their last values outside the access cycle.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign a_done    = r_a_done;
  assign b_done    = r_b_done;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                                |
// | Purpose : Scoreboard bench for dmem_arbiter with a behavioural memory,   |
// |           a transaction-level reference model and a negedge monitor.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int M_NORMAL   = 0;
  localparam int M_SCRAMBLE = 1;
  localparam int M_DROP     = 2;
  localparam int M_KEEP     = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  drv_req;
  logic [1:0]  drv_we;
  logic [3:0]  drv_addr [2];
  logic [31:0] drv_wd   [2];

  wire         a_done;
  wire         b_done;
  wire  [31:0] a_rdata;
  wire  [31:0] b_rdata;
  wire         mem_en;
  wire         mem_we;
  wire  [3:0]  mem_addr;
  wire  [31:0] mem_wdata;
  wire  [31:0] mem_rdata;
  wire         busy;
  wire  [1:0]  done_v;

  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        who;
    logic [31:0] ard;
    logic [31:0] brd;
  } done_t;

  acc_t  acc_q  [$];
  done_t done_q [$];

  // reference model state
  logic [31:0] ref_mem [16];
  logic [31:0] ref_ard;
  logic [31:0] ref_brd;
  logic        ref_last;

  dmem_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (drv_req[0]),
    .a_we      (drv_we[0]),
    .a_addr    (drv_addr[0]),
    .a_wdata   (drv_wd[0]),
    .a_done    (a_done),
    .a_rdata   (a_rdata),
    .b_req     (drv_req[1]),
    .b_we      (drv_we[1]),
    .b_addr    (drv_addr[1]),
    .b_wdata   (drv_wd[1]),
    .b_done    (b_done),
    .b_rdata   (b_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  assign done_v    = {b_done, a_done};
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Record one serialized transaction in the reference model.
  task automatic model_txn(input int who, input logic we, input logic [3:0] addr,
                           input logic [31:0] wd);
    acc_t  ea;
    done_t ed;
    ea.we = we; ea.addr = addr; ea.wdata = wd;
    acc_q.push_back(ea);
    if (we) ref_mem[addr] = wd;
    else if (who == 0) ref_ard = ref_mem[addr];
    else ref_brd = ref_mem[addr];
    ref_last = (who != 0);
    ed.who = (who != 0); ed.ard = ref_ard; ed.brd = ref_brd;
    done_q.push_back(ed);
  endtask

  task automatic model_reset();
    ref_ard  = 32'h0;
    ref_brd  = 32'h0;
    ref_last = 1'b1;
  endtask

  // Drive one request and wait for its done; lat counts negedges from issue.
  task automatic issue(input int who, input logic we, input logic [3:0] addr,
                       input logic [31:0] wd, input int mode, input logic [3:0] alt,
                       output int lat);
    drv_req[who]  = 1'b1;
    drv_we[who]   = we;
    drv_addr[who] = addr;
    drv_wd[who]   = wd;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1 && mode == M_SCRAMBLE) begin
        drv_addr[who] = alt;
        drv_wd[who]   = $urandom;
        drv_we[who]   = ~we;
      end
      if (lat == 1 && mode == M_DROP) drv_req[who] = 1'b0;
      if (done_v[who]) break;
      if (lat >= 20) begin
        total++;
        bad++;
        $display("FAIL done_timeout: requester %0d got no done within %0d cycles", who, lat);
        break;
      end
    end
    if (mode != M_KEEP) drv_req[who] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One round from IDLE: the selected requesters raise req together.
  task automatic round(input bit use_a, input bit use_b,
                       input logic we_a, input logic [3:0] ad_a, input logic [31:0] wd_a,
                       input logic we_b, input logic [3:0] ad_b, input logic [31:0] wd_b,
                       input int mode_first, input logic [3:0] alt);
    logic        cwe [2];
    logic [3:0]  cad [2];
    logic [31:0] cwd [2];
    int first, second, l0, l1;
    cwe[0] = we_a; cad[0] = ad_a; cwd[0] = wd_a;
    cwe[1] = we_b; cad[1] = ad_b; cwd[1] = wd_b;
    if (use_a && use_b) first = (ref_last == 1'b1) ? 0 : 1;
    else first = use_a ? 0 : 1;
    second = 1 - first;
    model_txn(first, cwe[first], cad[first], cwd[first]);
    if (use_a && use_b) begin
      model_txn(second, cwe[second], cad[second], cwd[second]);
      fork
        issue(first, cwe[first], cad[first], cwd[first], mode_first, alt, l0);
        issue(second, cwe[second], cad[second], cwd[second], M_NORMAL, alt, l1);
      join
      chk("latency_first", l0, 2);
      chk("latency_second", l1, 5);
    end else begin
      issue(first, cwe[first], cad[first], cwd[first], mode_first, alt, l0);
      chk("latency_single", l0, 2);
    end
    idle(1 + $urandom_range(0, 2));
  endtask

  // Both requesters keep req asserted for four transactions each.
  task automatic stream();
    logic        sw [2][4];
    logic [3:0]  sa [2][4];
    logic [31:0] sd [2][4];
    int first;
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) begin
        sw[w][k] = 1'($urandom_range(0, 1));
        sa[w][k] = 4'($urandom_range(0, 15));
        sd[w][k] = $urandom;
      end
    first = (ref_last == 1'b1) ? 0 : 1;
    for (int k = 0; k < 4; k++) begin
      model_txn(first, sw[first][k], sa[first][k], sd[first][k]);
      model_txn(1 - first, sw[1-first][k], sa[1-first][k], sd[1-first][k]);
    end
    fork
      begin
        int l;
        for (int k = 0; k < 4; k++) begin
          issue(0, sw[0][k], sa[0][k], sd[0][k], (k < 3) ? M_KEEP : M_NORMAL, 4'h0, l);
          chk("stream_lat_a", l, (k == 0) ? ((first == 0) ? 2 : 5) : 6);
        end
      end
      begin
        int l;
        for (int k = 0; k < 4; k++) begin
          issue(1, sw[1][k], sa[1][k], sd[1][k], (k < 3) ? M_KEEP : M_NORMAL, 4'h0, l);
          chk("stream_lat_b", l, (k == 0) ? ((first == 1) ? 2 : 5) : 6);
        end
      end
    join
    idle(2);
  endtask

  // Monitor: compares every memory access and every done against the queues.
  logic  prev_en = 1'b0;
  acc_t  m_acc;
  done_t m_done;

  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (mem_en) begin
        chk("mem_en_consecutive", {31'h0, prev_en}, 32'h0);
        chk("busy_in_access", {31'h0, busy}, 32'h1);
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_access: addr %h we %b with nothing pending", mem_addr, mem_we);
        end else begin
          m_acc = acc_q.pop_front();
          chk("mem_we", {31'h0, mem_we}, {31'h0, m_acc.we});
          chk("mem_addr", {28'h0, mem_addr}, {28'h0, m_acc.addr});
          chk("mem_wdata", mem_wdata, m_acc.wdata);
        end
      end
      if (a_done || b_done) begin
        chk("done_exclusive", {31'h0, a_done & b_done}, 32'h0);
        chk("resp_mem_we", {31'h0, mem_we}, 32'h0);
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: a_done %b b_done %b with nothing pending", a_done, b_done);
        end else begin
          m_done = done_q.pop_front();
          chk("done_who", {31'h0, b_done}, {31'h0, m_done.who});
          chk("a_rdata", a_rdata, m_done.ard);
          chk("b_rdata", b_rdata, m_done.brd);
        end
      end
      prev_en = mem_en;
    end
  end

  initial begin
    rst = 1'b1;
    drv_req = 2'b00;
    drv_we  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drv_addr[i] = 4'h0;
      drv_wd[i]   = 32'h0;
    end
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_reset();

    // reset state
    idle(3);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {28'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_dones", {30'h0, done_v}, 32'h0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_rdata", b_rdata, 32'h0);
    rst = 1'b0;
    idle(1);

    // A store then load of addr 5
    round(1, 0, 1'b1, 4'd5, 32'h0000_00AA, 1'b0, 4'd0, 32'h0, M_NORMAL, 4'h0);
    round(1, 0, 1'b0, 4'd5, 32'h0, 1'b0, 4'd0, 32'h0, M_NORMAL, 4'h0);
    chk("a_rdata_hold", a_rdata, 32'h0000_00AA);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("async_rst_a_rdata", a_rdata, 32'h0);
    chk("async_rst_b_rdata", b_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // simultaneous stores straight out of reset, then continuous traffic
    round(1, 1, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, M_NORMAL, 4'h0);
    stream();
    round(1, 1, 1'b1, 4'd2, 32'h22, 1'b1, 4'd9, 32'h99, M_NORMAL, 4'h0);
    round(1, 0, 1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0, M_NORMAL, 4'h0);

    // command stability: addr changes 3 -> 9 during ACCESS
    round(1, 0, 1'b0, 4'd3, 32'h0, 1'b0, 4'd0, 32'h0, M_SCRAMBLE, 4'd9);
    chk("stable_a_rdata", a_rdata, 32'h33);

    // abandoned B load of addr 2
    round(0, 1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd2, 32'h0, M_DROP, 4'h0);
    chk("abandon_b_rdata", b_rdata, 32'h22);
    idle(4);

    // reset during ACCESS of an A store of 0x77 to addr 4
    drv_req[0] = 1'b1; drv_we[0] = 1'b1; drv_addr[0] = 4'd4; drv_wd[0] = 32'h77;
    @(posedge clk);
    #1;
    chk("abort_access_en", {31'h0, mem_en}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_en_drop", {31'h0, mem_en}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_no_done", {31'h0, a_done}, 32'h0);
    drv_req[0] = 1'b0;
    model_reset();
    idle(2);
    rst = 1'b0;
    chk("abort_no_write", mem[4], ref_mem[4]);
    idle(1);
    round(1, 1, 1'b0, 4'd4, 32'h0, 1'b0, 4'd2, 32'h0, M_NORMAL, 4'h0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      round(sel[0], sel[1],
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 2), 4'($urandom_range(0, 15)));
    end
    stream();

    idle(4);
    chk("acc_queue_empty", acc_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
